ysyx_23060208_ifu: RTL
======================

Name: ysyx_23060208_ifu

Overview:
Instruction fetch unit for the multi-cycle NPC core, directly downstream of the PC register. It latches the current pc when fetch is enabled and issues a single-beat read on an AXI4-Lite-style AR/R channel to instruction memory (MROM/flash/SRAM via crossbar). It returns the instruction word and its pc, with an error code, to the IDU over a valid/ready handshake. It also keeps fetch performance counters.

Parameters:
DATA_WIDTH, 32, instruction/data bus width
ADDR_WIDTH, 32, address/pc width
RESP_WIDTH, 2, bus response width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc  in  ADDR_WIDTH  current pc from PC register
fetch_en  in  1  one-cycle pulse: pc is valid, start fetch (from WBU after PC write)
araddr  out  ADDR_WIDTH  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_WIDTH  read data
rresp  in  RESP_WIDTH  read response (0 = OKAY)
rvalid  in  1  read data valid
rready  out  1  read data ready
out_inst  out  DATA_WIDTH  fetched instruction
out_pc  out  ADDR_WIDTH  pc of out_inst
out_err  out  2  0 = none, 1 = access fault, 2 = misaligned
out_valid  out  1  instruction valid to IDU
out_ready  in  1  IDU accepts
busy  out  1  high in any state except IDLE
fetch_cnt  out  32  completed fetches (out handshakes)
stall_cnt  out  32  cycles spent in REQ or WAIT

Behaviour:
- Reset values: state IDLE; arvalid, rready, out_valid, busy = 0; araddr, out_inst, out_pc, out_err = 0; both counters = 0.
- After reset, no fetch until the first fetch_en. The PC register's reset value is never fetched.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - fetch_en=1 and pc[1:0]==0: latch pc into addr_r, go to REQ.
  - fetch_en=1 and pc[1:0]!=0: latch pc, out_inst=0, out_err=2, go to HOLD. No bus request is issued.
  - fetch_en=0: stay in IDLE.
- REQ: arvalid=1, araddr=addr_r; both stay stable until arready. On arvalid&arready, go to WAIT next cycle.
- WAIT: rready=1. On rvalid, register rdata into out_inst, set out_err = (rresp!=0) ? 1 : 0, go to HOLD.
  - rvalid during IDLE/REQ/HOLD is ignored (rready=0).
- HOLD: out_valid=1; out_inst, out_pc, out_err stay stable. On out_ready, go to IDLE and increment fetch_cnt. out_ready may already be high on HOLD entry.
- Minimum latency, fetch_en to out_valid:
  - 3 cycles with arready already high and rvalid the cycle after the AR handshake.
  - 1 cycle for the misaligned path.
- fetch_en outside IDLE is ignored, and no second fetch is queued.
- stall_cnt increments every cycle the state is REQ or WAIT. Both counters wrap modulo 2^32.
- rst asserted in any state returns to IDLE next cycle with all outputs at reset values. Any outstanding R beat is then dropped, because rready=0 in IDLE.
- out_pc equals addr_r, the pc latched at fetch_en, not the live pc input.

Decomposition:
- Shared package ysyx_23060208_pkg holds:
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2, HOLD=3).
  - IFU error codes (ERR_NONE, ERR_ACCESS, ERR_MISALIGN).
  - RESP_OKAY constant.
- One natural sub-module: ysyx_23060208_perf_cnt, a 32-bit counter with inc and synchronous clear, instantiated twice.

Test Plan:
- Basic fetch: rst 2 cycles, then fetch_en with pc=0x3000_0000, arready=1, rvalid one cycle after AR handshake with rdata=0x00000413, rresp=0, out_ready=1.
  -> araddr=0x3000_0000; out_valid 3 cycles after fetch_en with out_inst=0x00000413, out_pc=0x3000_0000, out_err=0; fetch_cnt=1, stall_cnt=2.
- Backpressure: arready held low 4 cycles, rvalid delayed 3 cycles, out_ready low 5 cycles in HOLD.
  -> arvalid/araddr stable throughout; out_* stable for 5 cycles; exactly one handshake; stall_cnt=4+1+3.
- Access fault: rresp=2'b10 with rdata=0xDEADBEEF.
  -> out_err=1, out_inst=0xDEADBEEF, out_valid asserted.
- Misaligned pc: fetch_en with pc=0x3000_0002.
  -> arvalid never asserts; next cycle out_valid=1, out_err=2, out_inst=0, out_pc=0x3000_0002.
- Spurious fetch_en: fetch_en pulsed again while in WAIT, and pc changed to 0x3000_0010.
  -> ignored; out_pc stays at the original address; only one AR handshake occurs.
- Reset mid-operation: rst asserted in WAIT, then rvalid=1 the next cycle.
  -> IDLE, rready=0, out_valid=0, counters=0; a following normal fetch completes correctly.

Source files
------------

// File: rtl/ysyx_23060208_pkg.sv
// Shared constants for the ysyx_23060208 NPC core slice.
// FSM encoding for the fetch unit, IFU error codes and bus response codes.
// Pure constants; no logic.
package ysyx_23060208_pkg;

  // Fetch unit states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Error codes reported with each fetched instruction
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ACCESS   = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

  // Bus read response: anything other than OKAY is treated as an access fault
  localparam logic [1:0] RESP_OKAY = 2'd0;

endpackage

// File: rtl/ysyx_23060208_perf_cnt.sv
// 32-bit performance counter with increment enable and synchronous clear.
// Latency: count visible the cycle after inc. Wraps modulo 2^32.
// No backpressure; clear has priority over increment.
module ysyx_23060208_perf_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  // Clear wins; otherwise count up by one on each inc cycle
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= 32'd0;
    else if (inc)
      cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/ysyx_23060208_ifu.sv
// Instruction fetch unit: latches pc on fetch_en, does one AR/R read, hands inst to IDU.
// Latency: 3 cycles fetch_en->out_valid with zero-wait bus, 1 cycle for misaligned pc.
// Backpressure: AR held stable until arready, result held stable until out_ready.
module ysyx_23060208_ifu
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [RESP_WIDTH-1:0] rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [1:0]            out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic [1:0]            err_r;

  // Fetch FSM; addr_r is the pc captured at fetch_en and doubles as araddr/out_pc,
  // so later changes on the live pc input never leak into an in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_r <= '0;
      inst_r <= '0;
      err_r  <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en) begin
            addr_r <= pc;
            if (pc[1:0] != 2'b00) begin
              // Misaligned: report directly, never touch the bus
              inst_r <= '0;
              err_r  <= ERR_MISALIGN;
              state  <= S_HOLD;
            end else begin
              state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (arready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (rvalid) begin
            inst_r <= rdata;
            err_r  <= (rresp != RESP_WIDTH'(RESP_OKAY)) ? ERR_ACCESS : ERR_NONE;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign araddr    = addr_r;
  assign arvalid   = (state == S_REQ);
  assign rready    = (state == S_WAIT);
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign out_inst  = inst_r;
  assign out_pc    = addr_r;
  assign out_err   = err_r;

  // Completed fetches: one per IDU handshake
  ysyx_23060208_perf_cnt u_fetch_cnt (
    .clk (clk),
    .clr (rst),
    .inc (out_valid & out_ready),
    .cnt (fetch_cnt)
  );

  // Cycles spent waiting on the bus (REQ or WAIT)
  ysyx_23060208_perf_cnt u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc ((state == S_REQ) | (state == S_WAIT)),
    .cnt (stall_cnt)
  );

endmodule
